// File: rtl/conv_layer_tile_scheduler.sv
// conv_layer_tile_scheduler
// Walks conv_tile over a whole convolution layer. Tile bases are visited in
// row, col, n, m order (m innermost) so partial sums for one output tile
// accumulate across all input-channel tiles before the walk moves on.
// For each tile the scheduler fires a one-cycle tile_start, holds the bases
// steady until tile_done, then idles for GAP cycles before the next tile.
module conv_layer_tile_scheduler #(
  parameter int unsigned AW  = 32,
  parameter int unsigned N   = 32,
  parameter int unsigned M   = 32,
  parameter int unsigned R   = 64,
  parameter int unsigned C   = 32,
  parameter int unsigned Tn  = 16,
  parameter int unsigned Tm  = 16,
  parameter int unsigned Tr  = 64,
  parameter int unsigned Tc  = 16,
  parameter int unsigned GAP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          layer_start,
  output logic          layer_done,
  output logic          busy,
  output logic          tile_start,
  input  logic          tile_done,
  output logic [AW-1:0] tile_base_n,
  output logic [AW-1:0] tile_base_m,
  output logic [AW-1:0] tile_base_row,
  output logic [AW-1:0] tile_base_col,
  output logic [AW-1:0] tile_cnt
);

  // The gap counter only ever holds GAP-1 down to 0.
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  localparam logic [AW-1:0] N_LAST   = AW'(N - Tn);
  localparam logic [AW-1:0] M_LAST   = AW'(M - Tm);
  localparam logic [AW-1:0] ROW_LAST = AW'(R - Tr);
  localparam logic [AW-1:0] COL_LAST = AW'(C - Tc);

  localparam logic [AW-1:0] N_STEP   = AW'(Tn);
  localparam logic [AW-1:0] M_STEP   = AW'(Tm);
  localparam logic [AW-1:0] ROW_STEP = AW'(Tr);
  localparam logic [AW-1:0] COL_STEP = AW'(Tc);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state;
  logic [GW-1:0] gap_cnt;

  logic          m_wrap;
  logic          n_wrap;
  logic          col_wrap;
  logic          row_wrap;
  logic          last_tile;

  logic [AW-1:0] next_n;
  logic [AW-1:0] next_m;
  logic [AW-1:0] next_row;
  logic [AW-1:0] next_col;

  // A loop wraps when its base sits on the last legal tile position.
  assign m_wrap    = (tile_base_m   == M_LAST);
  assign n_wrap    = (tile_base_n   == N_LAST);
  assign col_wrap  = (tile_base_col == COL_LAST);
  assign row_wrap  = (tile_base_row == ROW_LAST);
  assign last_tile = m_wrap && n_wrap && col_wrap && row_wrap;

  // Next-tile coordinates: m always steps, each wrap carries one loop outward.
  always_comb begin
    next_m   = m_wrap ? '0 : tile_base_m + M_STEP;
    next_n   = tile_base_n;
    next_col = tile_base_col;
    next_row = tile_base_row;
    if (m_wrap) begin
      next_n = n_wrap ? '0 : tile_base_n + N_STEP;
    end
    if (m_wrap && n_wrap) begin
      next_col = col_wrap ? '0 : tile_base_col + COL_STEP;
    end
    if (m_wrap && n_wrap && col_wrap) begin
      next_row = row_wrap ? '0 : tile_base_row + ROW_STEP;
    end
  end

  // Layer walk FSM; every output is a register written alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      gap_cnt       <= '0;
      layer_done    <= 1'b0;
      busy          <= 1'b0;
      tile_start    <= 1'b0;
      tile_base_n   <= '0;
      tile_base_m   <= '0;
      tile_base_row <= '0;
      tile_base_col <= '0;
      tile_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (layer_start) begin
            tile_base_n   <= '0;
            tile_base_m   <= '0;
            tile_base_row <= '0;
            tile_base_col <= '0;
            tile_cnt      <= '0;
            tile_start    <= 1'b1;
            busy          <= 1'b1;
            state         <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          tile_start <= 1'b0;
          state      <= S_WAIT;
        end

        S_WAIT: begin
          if (tile_done) begin
            tile_cnt <= tile_cnt + AW'(1);
            if (last_tile) begin
              layer_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              tile_base_n   <= next_n;
              tile_base_m   <= next_m;
              tile_base_row <= next_row;
              tile_base_col <= next_col;
              gap_cnt       <= GAP_LOAD;
              state         <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == '0) begin
            tile_start <= 1'b1;
            state      <= S_ISSUE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end

        S_DONE: begin
          layer_done <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          layer_done <= 1'b0;
          busy       <= 1'b0;
          tile_start <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_tile_scheduler.sv
// tb_conv_layer_tile_scheduler
// Drives a 4x4x4x4 layer with 2-wide tiles (16 tiles) and a single-tile
// layer. A timestamp-level model predicts every output each cycle; directed
// literal expectations pin the tile order, timing and reset behaviour.
module tb_conv_layer_tile_scheduler;

  localparam int AW   = 32;
  localparam int DIM  = 4;
  localparam int STEP = 2;
  localparam int GAP  = 2;
  localparam int LAT  = 5;
  localparam int PER  = DIM / STEP;
  localparam int T    = PER * PER * PER * PER;

  typedef struct {
    longint c;
    int     n;
    int     m;
    int     row;
    int     col;
    int     cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          layer_start    = 1'b0;
  logic          tile_done_auto = 1'b0;
  logic          tile_done_inj  = 1'b0;
  logic          tile_done;
  logic          layer_done;
  logic          busy;
  logic          tile_start;
  logic [AW-1:0] tile_base_n;
  logic [AW-1:0] tile_base_m;
  logic [AW-1:0] tile_base_row;
  logic [AW-1:0] tile_base_col;
  logic [AW-1:0] tile_cnt;

  logic          layer_start1 = 1'b0;
  logic          tile_done1   = 1'b0;
  logic          layer_done1;
  logic          busy1;
  logic          tile_start1;
  logic [AW-1:0] b1_n;
  logic [AW-1:0] b1_m;
  logic [AW-1:0] b1_row;
  logic [AW-1:0] b1_col;
  logic [AW-1:0] tile_cnt1;

  int     pass_cnt  = 0;
  int     total_cnt = 0;
  longint cyc       = 0;

  int exp_n   [T];
  int exp_m   [T];
  int exp_row [T];
  int exp_col [T];

  bit     m_active   = 1'b0;
  bit     m_waiting  = 1'b0;
  int     m_k        = 0;
  int     m_idx      = 0;
  longint m_issue_at = -1;
  longint m_done_at  = -1;

  ev_t    start_q[$];
  ev_t    done_q[$];
  longint tdone_q[$];

  bit     pend_valid = 1'b0;
  longint pend_at    = 0;
  logic   done_next  = 1'b0;

  assign tile_done = tile_done_auto | tile_done_inj;

  conv_layer_tile_scheduler #(
    .AW(AW), .N(DIM), .M(DIM), .R(DIM), .C(DIM),
    .Tn(STEP), .Tm(STEP), .Tr(STEP), .Tc(STEP), .GAP(GAP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .layer_start   (layer_start),
    .layer_done    (layer_done),
    .busy          (busy),
    .tile_start    (tile_start),
    .tile_done     (tile_done),
    .tile_base_n   (tile_base_n),
    .tile_base_m   (tile_base_m),
    .tile_base_row (tile_base_row),
    .tile_base_col (tile_base_col),
    .tile_cnt      (tile_cnt)
  );

  conv_layer_tile_scheduler #(
    .AW(AW), .N(DIM), .M(DIM), .R(DIM), .C(DIM),
    .Tn(DIM), .Tm(DIM), .Tr(DIM), .Tc(DIM), .GAP(GAP)
  ) dut1 (
    .clk           (clk),
    .rst           (rst),
    .layer_start   (layer_start1),
    .layer_done    (layer_done1),
    .busy          (busy1),
    .tile_start    (tile_start1),
    .tile_done     (tile_done1),
    .tile_base_n   (b1_n),
    .tile_base_m   (b1_m),
    .tile_base_row (b1_row),
    .tile_base_col (b1_col),
    .tile_cnt      (tile_cnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic logic [31:0] pack4(input int n, input int m, input int row, input int col);
    return {8'(n), 8'(m), 8'(row), 8'(col)};
  endfunction

  task automatic model_reset();
    m_active   = 1'b0;
    m_waiting  = 1'b0;
    m_k        = 0;
    m_idx      = 0;
    m_issue_at = -1;
    m_done_at  = -1;
  endtask

  // Tile-completion responder: answers each tile_start LAT cycles later.
  always @(negedge clk) begin
    done_next = 1'b0;
    if (!rst) begin
      pend_valid = 1'b0;
    end else begin
      if (tile_start) begin
        pend_valid = 1'b1;
        pend_at    = cyc + LAT;
      end
      if (pend_valid && (cyc + 1 == pend_at)) begin
        done_next  = 1'b1;
        pend_valid = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1 tile_done_auto = done_next;
  end

  // Per-cycle comparison against the timestamp model, then model advance.
  always @(negedge clk) begin : compare
    logic [255:0] act;
    logic [255:0] expv;
    logic         e_start;
    logic         e_done;
    logic         e_busy;
    ev_t          ev;
    if (!rst) model_reset();
    e_start = m_active && (cyc == m_issue_at);
    e_done  = (cyc == m_done_at);
    e_busy  = m_active || e_done;
    act  = {layer_done, busy, tile_start, tile_base_n, tile_base_m,
            tile_base_row, tile_base_col, tile_cnt};
    expv = {e_done, e_busy, e_start, AW'(exp_n[m_idx]), AW'(exp_m[m_idx]),
            AW'(exp_row[m_idx]), AW'(exp_col[m_idx]), AW'(m_k)};
    check("cycle_outputs", act, expv);

    ev.c   = cyc;
    ev.n   = int'(tile_base_n);
    ev.m   = int'(tile_base_m);
    ev.row = int'(tile_base_row);
    ev.col = int'(tile_base_col);
    ev.cnt = int'(tile_cnt);
    if (tile_start) start_q.push_back(ev);
    if (layer_done) done_q.push_back(ev);
    if (rst && tile_done_auto) tdone_q.push_back(cyc);

    if (rst) begin
      if (!m_active && (cyc != m_done_at)) begin
        if (layer_start) begin
          m_active   = 1'b1;
          m_waiting  = 1'b0;
          m_k        = 0;
          m_idx      = 0;
          m_issue_at = cyc + 1;
        end
      end else if (m_active) begin
        if (cyc == m_issue_at) begin
          m_waiting = 1'b1;
        end else if (m_waiting && tile_done) begin
          m_k++;
          m_waiting = 1'b0;
          if (m_k == T) begin
            m_active  = 1'b0;
            m_done_at = cyc + 1;
          end else begin
            m_idx++;
            m_issue_at = cyc + 1 + GAP;
          end
        end
      end
    end
  end

  task automatic pulse_layer_start(output longint t);
    @(posedge clk);
    #1 layer_start = 1'b1;
    t = cyc;
    @(posedge clk);
    #1 layer_start = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int i = 0;
    while (start_q.size() < n && i < budget) begin
      @(posedge clk);
      i++;
    end
    check(name, start_q.size() >= n, 1'b1);
  endtask

  task automatic wait_tdone(input int n, input int budget, input string name);
    int i = 0;
    while (tdone_q.size() < n && i < budget) begin
      @(posedge clk);
      i++;
    end
    check(name, tdone_q.size() >= n, 1'b1);
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int i = 0;
    while (done_q.size() < n && i < budget) begin
      @(posedge clk);
      i++;
    end
    check(name, done_q.size() >= n, 1'b1);
  endtask

  task automatic clear_logs();
    start_q.delete();
    done_q.delete();
    tdone_q.delete();
  endtask

  // Single-tile layer: one tile_start, layer_done one cycle after tile_done.
  task automatic applyStimulus_single();
    longint t;
    int     n_start  = 0;
    int     n_done   = 0;
    int     n_busy   = 0;
    int     start_at = -1;
    int     done_at  = -1;
    @(posedge clk);
    #1 layer_start1 = 1'b1;
    t = cyc;
    @(posedge clk);
    #1 layer_start1 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tile_done1 = (i == 1 + LAT);
      @(negedge clk);
      if (tile_start1) begin n_start++; start_at = i; end
      if (layer_done1) begin n_done++; done_at = i; end
      if (busy1) n_busy++;
      @(posedge clk);
      #1;
    end
    tile_done1 = 1'b0;
    check("t1_start_count", n_start, 1);
    check("t1_start_latency", start_at, 1);
    check("t1_done_count", n_done, 1);
    check("t1_done_latency", done_at, 7);
    check("t1_busy_cycles", n_busy, 7);
    check("t1_tile_cnt", tile_cnt1, 1);
    check("t1_bases", {b1_n, b1_m, b1_row, b1_col}, 0);
    check("t1_idle_after", {busy1, layer_done1, tile_start1}, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, run incomplete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    longint t;
    ev_t    s1[$];
    longint td1[$];
    ev_t    d1[$];
    int     idx = 0;

    for (int row = 0; row < DIM; row += STEP)
      for (int col = 0; col < DIM; col += STEP)
        for (int n = 0; n < DIM; n += STEP)
          for (int m = 0; m < DIM; m += STEP) begin
            exp_n[idx]   = n;
            exp_m[idx]   = m;
            exp_row[idx] = row;
            exp_col[idx] = col;
            idx++;
          end

    // Power-on reset
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {layer_done, busy, tile_start, tile_base_n, tile_base_m,
                            tile_base_row, tile_base_col, tile_cnt}, 0);
    check("reset_outputs_t1", {layer_done1, busy1, tile_start1, tile_cnt1}, 0);
    rst = 1'b1;

    // Spurious tile_done while idle
    @(posedge clk);
    #1 tile_done_inj = 1'b1;
    @(posedge clk);
    #1 tile_done_inj = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_done_ignored", {busy, tile_cnt}, 0);

    // Layer 1 with a spurious layer_start in WAIT and tile_done in GAP
    clear_logs();
    pulse_layer_start(t);
    wait_starts(1, 20, "l1_first_start_seen");
    #1 layer_start = 1'b1;
    @(posedge clk);
    #1 layer_start = 1'b0;
    wait_tdone(1, 20, "l1_first_tdone_seen");
    #1 tile_done_inj = 1'b1;
    @(posedge clk);
    #1 tile_done_inj = 1'b0;
    wait_done(1, 400, "l1_layer_done_seen");

    // Back-to-back: layer_start in the cycle right after layer_done
    s1  = start_q;
    td1 = tdone_q;
    d1  = done_q;
    clear_logs();
    #1 layer_start = 1'b1;
    @(posedge clk);
    #1 layer_start = 1'b0;

    check("l1_start_count", s1.size(), T);
    check("l1_done_count", d1.size(), 1);
    if (s1.size() == T && td1.size() == T && d1.size() == 1) begin
      check("l1_start_latency", s1[0].c - t, 1);
      check("l1_tile0", pack4(s1[0].n, s1[0].m, s1[0].row, s1[0].col), pack4(0, 0, 0, 0));
      check("l1_tile1", pack4(s1[1].n, s1[1].m, s1[1].row, s1[1].col), pack4(0, 2, 0, 0));
      check("l1_tile2", pack4(s1[2].n, s1[2].m, s1[2].row, s1[2].col), pack4(2, 0, 0, 0));
      check("l1_tile3", pack4(s1[3].n, s1[3].m, s1[3].row, s1[3].col), pack4(2, 2, 0, 0));
      check("l1_tile4", pack4(s1[4].n, s1[4].m, s1[4].row, s1[4].col), pack4(0, 0, 0, 2));
      check("l1_tile8", pack4(s1[8].n, s1[8].m, s1[8].row, s1[8].col), pack4(0, 0, 2, 0));
      check("l1_tile15", pack4(s1[15].n, s1[15].m, s1[15].row, s1[15].col), pack4(2, 2, 2, 2));
      check("l1_tile1_cnt", s1[1].cnt, 1);
      check("l1_done_to_start", s1[1].c - td1[0], 3);
      check("l1_last_done_latency", d1[0].c - td1[15], 1);
      check("l1_done_cnt", d1[0].cnt, 16);
      check("l1_done_bases", pack4(d1[0].n, d1[0].m, d1[0].row, d1[0].col), pack4(2, 2, 2, 2));
    end

    wait_done(1, 400, "l2_layer_done_seen");
    check("l2_start_count", start_q.size(), T);
    if (start_q.size() == T && d1.size() == 1) begin
      check("l2_back_to_back_start", start_q[0].c - d1[0].c, 2);
      check("l2_tile0", pack4(start_q[0].n, start_q[0].m, start_q[0].row, start_q[0].col), pack4(0, 0, 0, 0));
      check("l2_tile4", pack4(start_q[4].n, start_q[4].m, start_q[4].row, start_q[4].col), pack4(0, 0, 0, 2));
      check("l2_tile15", pack4(start_q[15].n, start_q[15].m, start_q[15].row, start_q[15].col), pack4(2, 2, 2, 2));
    end
    repeat (2) @(posedge clk);
    #1;
    check("l2_idle_cnt_held", {busy, tile_cnt}, {1'b0, AW'(16)});

    // Asynchronous reset during WAIT of the seventh tile
    clear_logs();
    pulse_layer_start(t);
    wait_starts(7, 200, "l3_seventh_start_seen");
    #1;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("reset_async_outputs", {layer_done, busy, tile_start, tile_base_n, tile_base_m,
                                  tile_base_row, tile_base_col, tile_cnt}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    clear_logs();
    pulse_layer_start(t);
    wait_starts(1, 20, "l4_first_start_seen");
    if (start_q.size() >= 1) begin
      check("l4_restart_tile0", pack4(start_q[0].n, start_q[0].m, start_q[0].row, start_q[0].col), pack4(0, 0, 0, 0));
      check("l4_restart_cnt", start_q[0].cnt, 0);
    end
    wait_done(1, 400, "l4_layer_done_seen");
    if (done_q.size() >= 1) check("l4_done_cnt", done_q[0].cnt, 16);

    applyStimulus_single();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
